// File: rtl/branch_ctrl.sv
// Branch-resolution controller for the ID stage: holds a branch until its operands are
// forwardable, evaluates the condition, and issues a registered one-cycle PC redirect.
module branch_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             br_valid,
   input  logic [2:0]       br_type,
   input  logic [31:0]      br_target,
   input  logic             rs_busy,
   input  logic             rt_busy,
   input  logic             flush,
   input  logic             cmp_eq,
   input  logic             cmp_gtz,
   input  logic             cmp_ltz,
   input  logic             cmp_eqz,
   output logic             stall,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic             hang,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT     = 2'd1,
      RESOLVED = 2'd2
   } state_t;

   localparam logic [2:0] BT_BEQ  = 3'b000;
   localparam logic [2:0] BT_BNE  = 3'b001;
   localparam logic [2:0] BT_BLEZ = 3'b010;
   localparam logic [2:0] BT_BGTZ = 3'b011;
   localparam logic [2:0] BT_BLTZ = 3'b100;
   localparam logic [2:0] BT_BGEZ = 3'b101;

   localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

   state_t            r_state;
   state_t            w_next_state;
   logic [7:0]        r_wait_cnt;
   logic [7:0]        w_wait_nxt;
   logic              r_redirect;
   logic [31:0]       r_redirect_pc;
   logic              r_hang;
   logic [CNT_W-1:0]  r_br_count;
   logic [CNT_W-1:0]  r_taken_count;
   logic [CNT_W-1:0]  r_stall_count;

   logic              w_need_rt;
   logic              w_busy;
   logic              w_stall;
   logic              w_resolve;
   logic              w_take;

   assign w_need_rt = (br_type == BT_BEQ) | (br_type == BT_BNE);
   assign w_busy    = rs_busy | (w_need_rt & rt_busy);
   assign w_stall   = br_valid & w_busy & ~flush;
   assign w_resolve = br_valid & ~w_busy & ~flush;

   always_comb begin
      w_take = 1'b0;
      case (br_type)
         BT_BEQ:  w_take = cmp_eq;
         BT_BNE:  w_take = ~cmp_eq;
         BT_BLEZ: w_take = cmp_ltz | cmp_eqz;
         BT_BGTZ: w_take = cmp_gtz;
         BT_BLTZ: w_take = cmp_ltz;
         BT_BGEZ: w_take = cmp_gtz | cmp_eqz;
         default: w_take = 1'b0;
      endcase
   end

   // RESOLVED accepts a new branch exactly like IDLE, so only WAIT differs (in wait counting).
   always_comb begin
      w_next_state = IDLE;
      case (r_state)
         IDLE, RESOLVED, WAIT: begin
            if (flush)          w_next_state = IDLE;
            else if (w_resolve) w_next_state = RESOLVED;
            else if (w_stall)   w_next_state = WAIT;
            else                w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_wait_nxt = 8'd0;
      if (w_stall) begin
         if (r_state == WAIT)
            w_wait_nxt = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;
         else
            w_wait_nxt = 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_wait_cnt <= 8'd0;
         r_hang     <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_wait_nxt;
         if (w_stall && (w_wait_nxt >= LP_MAX_WAIT))
            r_hang <= 1'b1;
      end
   end

   // The target only loads on a taken resolve so redirect_pc stays put while redirect is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_redirect    <= 1'b0;
         r_redirect_pc <= 32'd0;
      end else begin
         r_redirect <= w_resolve & w_take;
         if (w_resolve && w_take)
            r_redirect_pc <= br_target;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_br_count    <= '0;
         r_taken_count <= '0;
         r_stall_count <= '0;
      end else begin
         if (w_resolve)
            r_br_count <= r_br_count + CNT_W'(1);
         if (w_resolve && w_take)
            r_taken_count <= r_taken_count + CNT_W'(1);
         if (w_stall)
            r_stall_count <= r_stall_count + CNT_W'(1);
      end
   end

   assign stall       = w_stall;
   assign redirect    = r_redirect;
   assign redirect_pc = r_redirect_pc;
   assign hang        = r_hang;
   assign br_count    = r_br_count;
   assign taken_count = r_taken_count;
   assign stall_count = r_stall_count;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed table-driven bench for branch_ctrl plus hand sequences for multi-cycle corners.
module tb_branch_ctrl;

   logic        clk = 1'b0;
   logic        reset, br_valid, rs_busy, rt_busy, flush;
   logic [2:0]  br_type;
   logic [31:0] br_target;
   logic        cmp_eq, cmp_gtz, cmp_ltz, cmp_eqz;
   logic        stall, redirect, hang;
   logic [31:0] redirect_pc;
   logic [31:0] br_count, taken_count, stall_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   branch_ctrl #(.MAX_WAIT(15), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type),
      .br_target(br_target), .rs_busy(rs_busy), .rt_busy(rt_busy), .flush(flush),
      .cmp_eq(cmp_eq), .cmp_gtz(cmp_gtz), .cmp_ltz(cmp_ltz), .cmp_eqz(cmp_eqz),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .hang(hang),
      .br_count(br_count), .taken_count(taken_count), .stall_count(stall_count)
   );

   typedef struct packed {
      logic [2:0] ty;
      logic       rsb, rtb, fl;
      logic       eq, gtz, ltz, eqz;
      logic       exp_stall, exp_redir;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the edge, checks 2 units after.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      br_valid = 0; br_type = 3'b000; br_target = 32'h0;
      rs_busy = 0; rt_busy = 0; flush = 0;
      cmp_eq = 0; cmp_gtz = 0; cmp_ltz = 0; cmp_eqz = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic drive_br(input logic [2:0] ty, input logic [31:0] tgt,
                           input logic eq, input logic gtz, input logic ltz, input logic eqz);
      br_valid = 1; br_type = ty; br_target = tgt;
      cmp_eq = eq; cmp_gtz = gtz; cmp_ltz = ltz; cmp_eqz = eqz;
   endtask

   task automatic chk_counts(input string tag, input int b, input int t, input int s);
      chk({tag, ".br_count"}, br_count, b);
      chk({tag, ".taken_count"}, taken_count, t);
      chk({tag, ".stall_count"}, stall_count, s);
   endtask

   int exp_br, exp_tk, exp_st;

   initial begin
      reset = 1;
      idle_inputs();

      // Reset state
      do_reset();
      #1;
      chk("rst.redirect", redirect, 0);
      chk("rst.redirect_pc", redirect_pc, 0);
      chk("rst.hang", hang, 0);
      chk("rst.stall", stall, 0);
      chk_counts("rst", 0, 0, 0);

      // BEQ taken, operands ready
      tick();
      drive_br(3'b000, 32'h0000_3010, 1, 0, 0, 0);
      #1 chk("beq.stall", stall, 0);
      tick();
      idle_inputs();
      #1;
      chk("beq.redirect", redirect, 1);
      chk("beq.redirect_pc", redirect_pc, 32'h0000_3010);
      chk_counts("beq", 1, 1, 0);
      tick();
      #1 chk("beq.redirect_1cyc", redirect, 0);

      // BNE with rt busy two cycles, cmp_eq=1 -> not taken
      do_reset();
      drive_br(3'b001, 32'h0000_4000, 1, 0, 0, 0);
      rt_busy = 1;
      #1 chk("bne.stall_c1", stall, 1);
      tick();
      #1 chk("bne.stall_c2", stall, 1);
      tick();
      rt_busy = 0;
      #1 chk("bne.stall_c3", stall, 0);
      tick();
      idle_inputs();
      #1;
      chk("bne.redirect", redirect, 0);
      chk_counts("bne", 1, 0, 2);

      // BGTZ ignores rt_busy
      do_reset();
      drive_br(3'b011, 32'h0000_5004, 0, 1, 0, 0);
      rt_busy = 1;
      #1 chk("bgtz.stall", stall, 0);
      tick();
      idle_inputs();
      #1;
      chk("bgtz.redirect", redirect, 1);
      chk("bgtz.redirect_pc", redirect_pc, 32'h0000_5004);

      // BLEZ stuck on rs_busy: hang after MAX_WAIT stall cycles, then flush
      do_reset();
      drive_br(3'b010, 32'h0000_6000, 0, 0, 0, 1);
      rs_busy = 1;
      for (int k = 1; k <= 14; k++) tick();
      #1;
      chk("hang.before", hang, 0);
      chk("hang.stall", stall, 1);
      tick();
      #1 chk("hang.at15", hang, 1);
      tick();
      flush = 1;
      #1 chk("hang.flush_stall", stall, 0);
      tick();
      idle_inputs();
      #1;
      chk("hang.flush_redirect", redirect, 0);
      chk("hang.sticky", hang, 1);
      chk_counts("hang", 0, 0, 16);
      tick();
      #1 chk("hang.sticky2", hang, 1);

      // Back-to-back: BGEZ taken then BLTZ not taken
      do_reset();
      drive_br(3'b101, 32'h0000_7000, 0, 0, 0, 1);
      tick();
      drive_br(3'b100, 32'h0000_7100, 0, 1, 0, 0);
      #1;
      chk("b2b.redirect1", redirect, 1);
      chk("b2b.redirect_pc1", redirect_pc, 32'h0000_7000);
      chk("b2b.stall", stall, 0);
      tick();
      idle_inputs();
      #1;
      chk("b2b.redirect2", redirect, 0);
      chk_counts("b2b", 2, 1, 0);

      // Reset while a redirect is pending
      do_reset();
      drive_br(3'b000, 32'h0000_8000, 1, 0, 0, 0);
      reset = 1;
      tick();
      reset = 0;
      idle_inputs();
      #1;
      chk("rstpend.redirect", redirect, 0);
      chk("rstpend.hang", hang, 0);
      chk_counts("rstpend", 0, 0, 0);

      // Table: one branch per entry, then br_valid drops
      //        ty      rsb  rtb  fl   eq   gtz  ltz  eqz  stall redir
      tbl[0]  = {3'b000, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1};
      tbl[1]  = {3'b000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0};
      tbl[2]  = {3'b001, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1};
      tbl[3]  = {3'b001, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0};
      tbl[4]  = {3'b010, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1};
      tbl[5]  = {3'b010, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0};
      tbl[6]  = {3'b011, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1};
      tbl[7]  = {3'b100, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1};
      tbl[8]  = {3'b101, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0};
      tbl[9]  = {3'b101, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1};
      tbl[10] = {3'b110, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0};
      tbl[11] = {3'b000, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0};
      tbl[12] = {3'b000, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0};
      tbl[13] = {3'b100, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0};
      tbl[14] = {3'b111, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0};

      do_reset();
      exp_br = 0; exp_tk = 0; exp_st = 0;
      for (int i = 0; i < 15; i++) begin
         drive_br(tbl[i].ty, 32'h0000_1000 + 32'(i) * 4, tbl[i].eq, tbl[i].gtz,
                  tbl[i].ltz, tbl[i].eqz);
         rs_busy = tbl[i].rsb; rt_busy = tbl[i].rtb; flush = tbl[i].fl;
         #1 chk($sformatf("vec%0d.stall", i), stall, tbl[i].exp_stall);
         if (!tbl[i].exp_stall && !tbl[i].fl) exp_br++;
         if (tbl[i].exp_redir) exp_tk++;
         if (tbl[i].exp_stall) exp_st++;
         tick();
         idle_inputs();
         #1;
         chk($sformatf("vec%0d.redirect", i), redirect, tbl[i].exp_redir);
         if (tbl[i].exp_redir)
            chk($sformatf("vec%0d.redirect_pc", i), redirect_pc, 32'h0000_1000 + 32'(i) * 4);
         chk_counts($sformatf("vec%0d", i), exp_br, exp_tk, exp_st);
         tick();
         #1 chk($sformatf("vec%0d.redirect_off", i), redirect, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Branch-resolution controller in the ID stage of the pipelined MIPS core.
- Holds a decoded branch until its operands are forwardable, evaluates the branch condition from the comparator flags, and issues a registered one-cycle PC redirect.
- Keeps branch/taken/stall statistics counters and a watchdog flag for stalls that never clear.
- Sits between the decoder/hazard unit, the register comparator, and the PC-select mux.

Parameters:
- MAX_WAIT, 15, stall cycles in WAIT before `hang` is raised (1..255).
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- br_valid  in  1  decoded branch present in ID; ID holds it stable while `stall`=1
- br_type  in  3  000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ, 110/111 reserved
- br_target  in  32  branch target address computed in ID
- rs_busy  in  1  rs value not yet forwardable (load in EX/MEM, etc.)
- rt_busy  in  1  rt value not yet forwardable
- flush  in  1  pipeline flush (exception/eret); aborts the branch in ID
- cmp_eq  in  1  rs==rt
- cmp_gtz  in  1  rs>0 (signed)
- cmp_ltz  in  1  rs<0 (signed)
- cmp_eqz  in  1  rs==0
- stall  out  1  freeze PC and IF/ID (combinational)
- redirect  out  1  registered one-cycle pulse: select `redirect_pc` for the next fetch
- redirect_pc  out  32  registered target, valid while `redirect`=1
- hang  out  1  sticky watchdog flag
- br_count  out  CNT_W  branches resolved
- taken_count  out  CNT_W  branches taken
- stall_count  out  CNT_W  total branch stall cycles

Behaviour:
- Reset (synchronous, evaluated only on the rising edge of `clk`):
  - state=IDLE.
  - redirect=0, redirect_pc=0, hang=0.
  - All counters and the internal wait counter cleared to 0.
- Operand dependency:
  - need_rt = (br_type==000 | br_type==001).
  - busy = rs_busy | (need_rt & rt_busy).
- Stall:
  - stall = br_valid & busy & ~flush, combinational, in every state.
- Condition (combinational `take`):
  - BEQ: cmp_eq. BNE: ~cmp_eq.
  - BLEZ: cmp_ltz|cmp_eqz. BGTZ: cmp_gtz.
  - BLTZ: cmp_ltz. BGEZ: cmp_gtz|cmp_eqz.
  - Reserved codes: take=0, still counted as a branch.
- resolve = br_valid & ~busy & ~flush.
- States:
  - IDLE:
    - resolve → RESOLVED.
    - br_valid & busy & ~flush → WAIT, wait_cnt=1.
    - Otherwise remain in IDLE.
  - WAIT:
    - flush → IDLE, with no redirect and no br_count increment.
    - resolve → RESOLVED.
    - Still busy → wait_cnt+1 (saturates at 255). When wait_cnt reaches MAX_WAIT, hang<=1; hang stays set until reset.
    - br_valid falling while busy is a protocol error: → IDLE silently.
  - RESOLVED (one cycle):
    - redirect=take_q, redirect_pc=br_target_q.
    - A new branch may be presented in this cycle (back-to-back branches); it is handled exactly as in IDLE.
    - Otherwise → IDLE.
- Latency: `redirect` is asserted the cycle after the cycle in which resolve=1. The `redirect` register is loaded with take on resolve and cleared on every other cycle, so it is never high for two consecutive cycles from a single branch.
- On resolve:
  - br_count += 1.
  - If take, taken_count += 1.
- stall_count += 1 every cycle that stall=1.
- Counters wrap modulo 2^CNT_W.
- Simultaneous events:
  - flush has priority over resolve and over stall.
  - reset has priority over everything.
  - A reset during WAIT or RESOLVED drops any pending redirect.
- redirect_pc holds its last value when redirect=0.

Test Plan:
- Reset, then BEQ (br_type 000), rs_busy=rt_busy=0, cmp_eq=1, br_target=0x00003010 → stall=0; redirect=1 next cycle with redirect_pc=0x00003010; br_count=1, taken_count=1.
- BNE with rt_busy=1 for 2 cycles, then 0, cmp_eq=1 → stall high exactly 2 cycles; redirect=0 after resolve; stall_count=2, br_count=1, taken_count=0.
- BGTZ with rt_busy=1, rs_busy=0, cmp_gtz=1 → no stall (rt ignored); redirect=1 the next cycle.
- BLEZ with rs_busy held high for 15 cycles (MAX_WAIT=15) → hang=1 on cycle 15 and stays set; then flush=1 → IDLE, no redirect, br_count unchanged.
- Back-to-back: BGEZ taken (cmp_eqz=1) resolves, next cycle BLTZ with cmp_ltz=0 → two single-cycle redirect values 1 then 0 on consecutive cycles; br_count=2, taken_count=1.
- Reset asserted in the RESOLVED-pending cycle → redirect=0, all counters 0, hang=0 on the next edge.
